// File: rtl/build_info_axil_if.sv
// AXI4-Lite bus bundle for the build-info register block.
// The master modport drives requests; the slave modport returns responses.
// Widths follow ADDR_W; the data path is fixed at 32 bits.
interface build_info_axil_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );
endinterface

// File: rtl/build_info_axil.sv
// Read-only AXI4-Lite slave exposing build version, USR_ACCESS word and capture status.
// Latency: rvalid one cycle after AR handshake; bvalid one cycle after the last AW/W beat.
// Backpressure: one outstanding read and one outstanding write; ready drops until R/B is taken.
module build_info_axil #(
  parameter int          ADDR_W      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  BLOCK_ID    = 8'hB1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          version_i,
  input  logic                 usr_access_datavalid_i,
  input  logic [31:0]          usr_access_data_i,
  build_info_axil_if.slave     axi
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;

  // ---------------------------------------------------------------
  // DATAVALID resynchronisation and rising-edge detect
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   cap_rise;

  // Shift DATAVALID through the synchroniser, then keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], usr_access_datavalid_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cap_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // ---------------------------------------------------------------
  // Capture registers
  // ---------------------------------------------------------------
  logic [31:0] usr_data_q;
  logic        captured_q;
  logic [7:0]  cap_count_q;
  logic [31:0] status_w;

  // Load the USR_ACCESS word on each synced rising edge; the count saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      usr_data_q  <= '0;
      captured_q  <= 1'b0;
      cap_count_q <= '0;
    end else if (cap_rise) begin
      usr_data_q <= usr_access_data_i;
      captured_q <= 1'b1;
      if (cap_count_q != 8'hFF) begin
        cap_count_q <= cap_count_q + 8'd1;
      end
    end
  end

  assign status_w = {BLOCK_ID, 8'h00, cap_count_q, 7'h00, captured_q};

  // ---------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------
  r_state_t    r_state_q, r_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] snap_q, snap_d;
  logic        arready;
  logic        rvalid;
  logic        addr_oor;

  // Any address bit above the 16-byte window makes the access an error.
  assign addr_oor = (axi.s_axi_araddr >> 4) != '0;

  // Read state and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      snap_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      snap_q    <= snap_d;
    end
  end

  // Read next-state: decode on AR handshake, hold response until rready.
  // Register values are sampled pre-capture, so a simultaneous capture shows up on the next read.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    snap_d    = snap_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (axi.s_axi_arvalid) begin
          r_state_d = R_RESP;
          if (addr_oor) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rresp_d = RESP_OKAY;
            case (axi.s_axi_araddr[3:2])
              2'd0: begin
                rdata_d = version_i[31:0];
                snap_d  = version_i[63:32];
              end
              2'd1:    rdata_d = snap_q;
              2'd2:    rdata_d = usr_data_q;
              default: rdata_d = status_w;
            endcase
          end
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (axi.s_axi_rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign axi.s_axi_arready = arready;
  assign axi.s_axi_rvalid  = rvalid;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = rresp_q;

  // ---------------------------------------------------------------
  // Write channel: accepts and discards, always answers SLVERR
  // ---------------------------------------------------------------
  w_state_t w_state_q, w_state_d;
  logic     awready;
  logic     wready;
  logic     bvalid;
  logic     unused_wr;

  // Write address/data/strobe are never stored.
  assign unused_wr = ^{axi.s_axi_awaddr, axi.s_axi_wdata, axi.s_axi_wstrb};

  // Write state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  // Write next-state: collect AW and W in either order, then issue one B response.
  always_comb begin
    w_state_d = w_state_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (axi.s_axi_awvalid && axi.s_axi_wvalid) begin
          w_state_d = W_RESP;
        end else if (axi.s_axi_awvalid) begin
          w_state_d = W_WAIT_W;
        end else if (axi.s_axi_wvalid) begin
          w_state_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        wready = 1'b1;
        if (axi.s_axi_wvalid) begin
          w_state_d = W_RESP;
        end
      end
      W_WAIT_AW: begin
        awready = 1'b1;
        if (axi.s_axi_awvalid) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (axi.s_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign axi.s_axi_awready = awready;
  assign axi.s_axi_wready  = wready;
  assign axi.s_axi_bvalid  = bvalid;
  assign axi.s_axi_bresp   = bvalid ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_build_info_axil.sv
// Self-checking bench for build_info_axil: table-driven reads, hand-written corner sequences,
// and a randomized phase scored against a register-level model of the block.
module tb_build_info_axil;
  localparam int AW   = 8;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] version = 64'h0123_4567_89AB_CDEF;
  logic        dv = 1'b0;
  logic [31:0] usr_data = '0;

  build_info_axil_if #(.ADDR_W(AW)) bus ();

  build_info_axil #(.ADDR_W(AW), .SYNC_STAGES(SYNC), .BLOCK_ID(8'hB1)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .version_i              (version),
    .usr_access_datavalid_i (dv),
    .usr_access_data_i      (usr_data),
    .axi                    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the four visible registers as plain variables.
  logic [31:0] m_snap = '0;
  logic [31:0] m_usr  = '0;
  int          m_cnt  = 0;
  bit          m_cap  = 1'b0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic model_reset();
    m_snap = '0; m_usr = '0; m_cnt = 0; m_cap = 1'b0;
  endtask

  // Expected read result from the register map; a VER_LO read refreshes the snapshot.
  task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx;
    if (a >= 8'h10) begin
      d = '0; r = 2'b10;
    end else begin
      r = 2'b00;
      idx = int'(a) / 4;
      case (idx)
        0: begin d = version[31:0]; m_snap = version[63:32]; end
        1: d = m_snap;
        2: d = m_usr;
        default: d = {8'hB1, 8'h00, 8'(m_cnt), 7'h00, m_cap};
      endcase
    end
  endtask

  task automatic model_capture(input logic [31:0] d);
    m_usr = d; m_cap = 1'b1;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    d = '0; r = '0;
    @(negedge clk);
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      timeout_fail("arready");
      bus.s_axi_arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      timeout_fail("rvalid");
      return;
    end
    d = bus.s_axi_rdata; r = bus.s_axi_rresp;
    bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    axi_read(a, d, r);
    model_read(a, ed, er);
    check({name, "_data"}, d, ed);
    check({name, "_resp"}, 32'(r), 32'(er));
  endtask

  // Present AW and W after independent delays; check the B response once both are taken.
  task automatic axi_write(input int aw_dly, input int w_dly);
    bit aw_fire = 0, w_fire = 0, aw_done = 0, w_done = 0;
    int c;
    bus.s_axi_awaddr = 8'($urandom); bus.s_axi_wdata = $urandom; bus.s_axi_wstrb = 4'hF;
    for (c = 0; c < 40 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      if (aw_fire) begin aw_done = 1; bus.s_axi_awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1;  bus.s_axi_wvalid  = 1'b0; end
      if (!aw_done && c >= aw_dly) bus.s_axi_awvalid = 1'b1;
      if (!w_done && c >= w_dly)   bus.s_axi_wvalid  = 1'b1;
      aw_fire = bus.s_axi_awvalid && bus.s_axi_awready;
      w_fire  = bus.s_axi_wvalid && bus.s_axi_wready;
    end
    if (!(aw_done && w_done)) begin
      bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
      timeout_fail("write_handshake");
      return;
    end
    check("bvalid_after_beats", 32'(bus.s_axi_bvalid), 32'd1);
    check("bresp_slverr", 32'(bus.s_axi_bresp), 32'd2);
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    check("bvalid_cleared", 32'(bus.s_axi_bvalid), 32'd0);
    check("aw_w_ready_back", {30'd0, bus.s_axi_awready, bus.s_axi_wready}, 32'd3);
  endtask

  task automatic capture(input logic [31:0] d);
    @(negedge clk);
    usr_data = d; dv = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    dv = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    model_capture(d);
  endtask

  initial begin
    logic [31:0] d, ed;
    logic [1:0]  r, er;

    tbl[0] = '{8'h0C, 32'hB100_0000, 2'b00};
    tbl[1] = '{8'h04, 32'h0000_0000, 2'b00};
    tbl[2] = '{8'h08, 32'h0000_0000, 2'b00};
    tbl[3] = '{8'h10, 32'h0000_0000, 2'b10};
    tbl[4] = '{8'h40, 32'h0000_0000, 2'b10};
    tbl[5] = '{8'h04, 32'h0000_0000, 2'b00};
    tbl[6] = '{8'h00, 32'h89AB_CDEF, 2'b00};
    tbl[7] = '{8'h05, 32'h0123_4567, 2'b00};
    tbl[8] = '{8'h03, 32'h89AB_CDEF, 2'b00};
    tbl[9] = '{8'h0F, 32'hB100_0000, 2'b00};

    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 0; bus.s_axi_rready = 0;
    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 0; bus.s_axi_bready = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_readies", {29'd0, bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 32'd7);
    check("reset_valids", {30'd0, bus.s_axi_rvalid, bus.s_axi_bvalid}, 32'd0);
    check("reset_rdata", bus.s_axi_rdata, 32'd0);

    // Table: register map, address aliasing, SLVERR window, snapshot defaults.
    for (int i = 0; i < 10; i++) begin
      axi_read(tbl[i].addr, d, r);
      model_read(tbl[i].addr, ed, er);
      check($sformatf("tbl%0d_data", i), d, tbl[i].exp_d);
      check($sformatf("tbl%0d_resp", i), 32'(r), 32'(tbl[i].exp_r));
    end

    // Snapshot coherence across a version change.
    read_check("ver_lo", 8'h00);
    version = 64'hFFFF_FFFF_0000_0000;
    axi_read(8'h04, d, r);
    model_read(8'h04, ed, er);
    check("snap_coherent", d, 32'h0123_4567);
    read_check("ver_lo_new", 8'h00);
    read_check("ver_hi_new", 8'h04);

    // First capture.
    capture(32'hDEAD_BEEF);
    axi_read(8'h08, d, r); model_read(8'h08, ed, er);
    check("usr_data_first", d, 32'hDEAD_BEEF);
    axi_read(8'h0C, d, r); model_read(8'h0C, ed, er);
    check("status_first", d, 32'hB100_0101);

    // Capture landing on the same edge as the USR_DATA AR handshake.
    @(negedge clk);
    usr_data = 32'h1234_5678; dv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rvalid_low_before_ar", 32'(bus.s_axi_rvalid), 32'd0);
    bus.s_axi_araddr = 8'h08; bus.s_axi_arvalid = 1'b1;
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    check("rvalid_next_cycle", 32'(bus.s_axi_rvalid), 32'd1);
    check("same_cycle_pre_capture", bus.s_axi_rdata, 32'hDEAD_BEEF);
    bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
    model_capture(32'h1234_5678);
    dv = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    read_check("same_cycle_post", 8'h08);
    axi_read(8'h0C, d, r); model_read(8'h0C, ed, er);
    check("status_two", d, 32'hB100_0201);

    // Saturation of the capture count.
    for (int i = 0; i < 254; i++) capture($urandom);
    axi_read(8'h0C, d, r); model_read(8'h0C, ed, er);
    check("count_saturated", d, 32'hB100_FF01);
    capture(32'hCAFE_F00D);
    axi_read(8'h0C, d, r); model_read(8'h0C, ed, er);
    check("count_held", d, 32'hB100_FF01);
    read_check("usr_after_sat", 8'h08);

    // rready held low: response stable, no new AR accepted.
    @(negedge clk);
    bus.s_axi_araddr = 8'h00; bus.s_axi_arvalid = 1'b1;
    @(negedge clk);
    bus.s_axi_araddr = 8'h08;
    model_read(8'h00, ed, er);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_rvalid", i), 32'(bus.s_axi_rvalid), 32'd1);
      check($sformatf("hold%0d_rdata", i), bus.s_axi_rdata, ed);
      check($sformatf("hold%0d_arready", i), 32'(bus.s_axi_arready), 32'd0);
      @(negedge clk);
    end
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
    check("hold_released", 32'(bus.s_axi_rvalid), 32'd0);

    // Writes in every beat order; none may change state.
    axi_write(3, 0);
    read_check("usr_after_w_first", 8'h08);
    axi_write(0, 0);
    axi_write(0, 2);
    read_check("status_after_writes", 8'h0C);

    // Reset during an unaccepted read response.
    @(negedge clk);
    bus.s_axi_araddr = 8'h08; bus.s_axi_arvalid = 1'b1;
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    check("pre_rst_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    check("rst_async_arready", 32'(bus.s_axi_arready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    axi_read(8'h0C, d, r); model_read(8'h0C, ed, er);
    check("post_rst_status", d, 32'hB100_0000);
    read_check("post_rst_usr", 8'h08);
    read_check("post_rst_snap", 8'h04);

    // Randomized mix scored against the model.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) begin
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        read_check("rand_rd", a);
      end else if (op < 7) begin
        capture($urandom);
      end else if (op < 8) begin
        version = {$urandom, $urandom};
      end else begin
        axi_write($urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    for (int a = 0; a < 16; a += 4) read_check("final_sweep", 8'(a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule
